fb_mig_line_writer: RTL and testbench
=====================================

# fb_mig_line_writer

Drains one completed framebuffer scanline, held in the frame-buffer cache's scanline bank, into DDR through the MIG user (app_*) write interface. It sits directly downstream of the scanline cache. The cache raises a line request with a DDR base address. This block then:
- reads the line back as 128-bit words (four RGBA8 pixels each);
- issues one MIG write command plus one write-data beat per word;
- obeys app_rdy and app_wdf_rdy independently;
- signals completion so the cache can recycle the bank.

## Interface
Parameters:
- ADDR_WIDTH, 27, MIG app_addr width.
- APP_DATA_WIDTH, 128, MIG app_wdf_data width (2 × nCK_PER_CLK × 16).
- LINE_WORDS, 160, 128-bit words per scanline (FRAMEBUFFER_WIDTH/4).
- ADDR_STEP, 8, app_addr increment per word.
- IDX_W, $clog2(LINE_WORDS), width of rd_idx.

Ports:
- clk  in  1  single clock; the MIG ui_clk domain.
- rst  in  1  asynchronous, active-high reset.
- line_req  in  1  the cache has a full scanline ready; level-held until line_ack.
- line_addr  in  ADDR_WIDTH  DDR address of word 0 of the line; sampled on the line_ack cycle.
- line_ack  out  1  one-cycle pulse: request accepted.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse: every word of the line has been accepted by the MIG.
- rd_idx  out  IDX_W  registered word index into the scanline bank.
- rd_data  in  APP_DATA_WIDTH  combinational read of the bank at rd_idx, valid in the same cycle.
- init_calib_complete  in  1  MIG calibration done.
- app_en  out  1  command valid.
- app_cmd  out  3  always 3'b000 (write).
- app_addr  out  ADDR_WIDTH  command address.
- app_rdy  in  1  command accepted when app_en && app_rdy.
- app_wdf_data  out  APP_DATA_WIDTH  write data.
- app_wdf_wren  out  1  data valid.
- app_wdf_end  out  1  always equals app_wdf_wren (one beat per burst).
- app_wdf_mask  out  APP_DATA_WIDTH/8  constant 0.
- app_wdf_rdy  in  1  data accepted when app_wdf_wren && app_wdf_rdy.

## Operation
The state machine has four states: IDLE, LOAD, ISSUE, DONE.

- **IDLE**
  - When line_req && init_calib_complete: pulse line_ack, latch line_addr into base, set rd_idx<=0 and beat count<=0, go to LOAD.
  - Otherwise stay in IDLE, with no ack.
  - A line_req while busy is ignored; it stays pending until the block is back in IDLE.
- **LOAD** (one cycle)
  - app_wdf_data<=rd_data (word 0), app_addr<=base.
  - app_en<=1, app_wdf_wren<=1, rd_idx<=1.
  - Go to ISSUE.
- **ISSUE**
  - Command and data are tracked independently:
    - app_en drops the cycle after a command acceptance.
    - app_wdf_wren drops the cycle after a data acceptance.
    - Each is held stable while pending: no change to addr or data until accepted.
  - The beat completes in a cycle where (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy).
  - On beat complete, if beat count == LINE_WORDS-1, go to DONE with app_en=app_wdf_wren=0.
  - On beat complete otherwise:
    - app_wdf_data<=rd_data; app_addr<=app_addr+ADDR_STEP, modulo 2^ADDR_WIDTH (wraps silently).
    - rd_idx<=rd_idx+1, saturating at LINE_WORDS-1; beat count+1.
    - Reassert both app_en and app_wdf_wren.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE.
- init_calib_complete is only checked in IDLE. A deassertion mid-line does not abort the line.

## Timing
- Reset (async) forces all of the following immediately, including mid-line. A partially written line is abandoned and never acked as done.
  - state=IDLE.
  - line_ack=0, done=0, busy=0.
  - rd_idx=0.
  - app_en=0, app_wdf_wren=0, app_wdf_end=0.
  - app_addr=0, app_wdf_data=0.
- Ack in cycle T gives:
  - LOAD in T+1.
  - First app_en/app_wdf_wren high in T+2.
- With app_rdy=app_wdf_rdy=1 continuously:
  - one beat per cycle;
  - last beat accepted in T+1+LINE_WORDS;
  - done in T+2+LINE_WORDS;
  - busy high from T+1 through T+2+LINE_WORDS.
- A back-to-back request is acked, at the earliest, the cycle after done.
- rd_idx always points at the next word to load, so rd_data for beat k+1 is stable during beat k.
- Data may be accepted before its command, or vice versa. There is never more than one command and one data beat outstanding.

## Test plan
- LINE_WORDS=4, ready always high, line_addr=0x100, word w = {4{w+1}} → app_addr 0x100, 0x108, 0x110, 0x118 on consecutive cycles with matching data; done 6 cycles after line_ack.
- app_rdy low for 3 cycles on beat 1 while app_wdf_rdy=1 → data beat 1 accepted once and wren drops; app_en and app_addr=0x108 held stable until app_rdy; beat 2 starts the following cycle.
- app_wdf_rdy low for 2 cycles on beat 2 while app_rdy=1 → command accepted first; data held; exactly 4 commands and 4 data beats in total.
- init_calib_complete=0 with line_req=1 for 10 cycles → no line_ack, busy=0, no app_en; calib rises → ack the next cycle.
- line_addr=27'h7FF_FFF8 → app_addr sequence 0x7FFFFF8, 0x0000000, 0x0000008, 0x0000010.
- rst asserted mid-ISSUE at beat 2 → app_en, wren and busy drop asynchronously with no done; the next request restarts from beat 0.

Source files
------------

// File: rtl/fb_mig_line_writer.sv
// ============================================================================
// Module      : fb_mig_line_writer
// Description : Streams one completed scanline from the cache bank into DDR
//               through the MIG app_* write interface, one beat per word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_mig_line_writer #(
    parameter int ADDR_WIDTH     = 27,
    parameter int APP_DATA_WIDTH = 128,
    parameter int LINE_WORDS     = 160,
    parameter int ADDR_STEP      = 8,
    parameter int IDX_W          = $clog2(LINE_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          line_req,
    input  logic [ADDR_WIDTH-1:0]         line_addr,
    output logic                          line_ack,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              rd_idx,
    input  logic [APP_DATA_WIDTH-1:0]     rd_data,
    input  logic                          init_calib_complete,
    output logic                          app_en,
    output logic [2:0]                    app_cmd,
    output logic [ADDR_WIDTH-1:0]         app_addr,
    input  logic                          app_rdy,
    output logic [APP_DATA_WIDTH-1:0]     app_wdf_data,
    output logic                          app_wdf_wren,
    output logic                          app_wdf_end,
    output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask,
    input  logic                          app_wdf_rdy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IDX_W-1:0]      C_LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] C_STEP     = ADDR_WIDTH'(ADDR_STEP);

    logic [1:0]                state_q,  state_d;
    logic [ADDR_WIDTH-1:0]     base_q,   base_d;
    logic [IDX_W-1:0]          rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]          beat_q,   beat_d;
    logic                      en_q,     en_d;
    logic                      wren_q,   wren_d;
    logic [ADDR_WIDTH-1:0]     addr_q,   addr_d;
    logic [APP_DATA_WIDTH-1:0] data_q,   data_d;

    logic w_accept;
    logic w_beat_done;

    assign w_accept    = (state_q == S_IDLE) && line_req && init_calib_complete;
    // Command and data channels retire independently; a beat is complete
    // once neither side still has anything pending.
    assign w_beat_done = (!en_q || app_rdy) && (!wren_q || app_wdf_rdy);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        rd_idx_d = rd_idx_q;
        beat_d   = beat_q;
        en_d     = en_q;
        wren_d   = wren_q;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    base_d   = line_addr;
                    rd_idx_d = '0;
                    beat_d   = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                data_d   = rd_data;
                addr_d   = base_q;
                en_d     = 1'b1;
                wren_d   = 1'b1;
                rd_idx_d = IDX_W'(1);
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_beat_done) begin
                    if (beat_q == C_LAST_IDX) begin
                        en_d    = 1'b0;
                        wren_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        data_d   = rd_data;
                        addr_d   = addr_q + C_STEP;
                        rd_idx_d = (rd_idx_q == C_LAST_IDX) ? rd_idx_q : rd_idx_q + IDX_W'(1);
                        beat_d   = beat_q + IDX_W'(1);
                        en_d     = 1'b1;
                        wren_d   = 1'b1;
                    end
                end else begin
                    if (en_q && app_rdy) begin
                        en_d = 1'b0;
                    end
                    if (wren_q && app_wdf_rdy) begin
                        wren_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            rd_idx_q <= '0;
            beat_q   <= '0;
            en_q     <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            rd_idx_q <= rd_idx_d;
            beat_q   <= beat_d;
            en_q     <= en_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Ack is masked by rst so a held request cannot appear accepted in reset.
    assign line_ack     = w_accept && !rst;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign rd_idx       = rd_idx_q;
    assign app_en       = en_q;
    assign app_cmd      = 3'b000;
    assign app_addr     = addr_q;
    assign app_wdf_data = data_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign app_wdf_mask = '0;

endmodule

`default_nettype wire

// File: tb/tb_fb_mig_line_writer.sv
// ============================================================================
// Module      : tb_fb_mig_line_writer
// Description : Scoreboard bench for fb_mig_line_writer with a 4-word line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_mig_line_writer;

    localparam int AW = 27;
    localparam int DW = 128;
    localparam int LW = 4;

    logic            clk;
    logic            rst;
    logic            line_req;
    logic [AW-1:0]   line_addr;
    logic            line_ack;
    logic            busy;
    logic            done;
    logic [1:0]      rd_idx;
    logic [DW-1:0]   rd_data;
    logic            init_calib_complete;
    logic            app_en;
    logic [2:0]      app_cmd;
    logic [AW-1:0]   app_addr;
    logic            app_rdy;
    logic [DW-1:0]   app_wdf_data;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic [DW/8-1:0] app_wdf_mask;
    logic            app_wdf_rdy;

    logic [DW-1:0]   bank [0:LW-1];
    assign rd_data = bank[rd_idx];

    fb_mig_line_writer #(
        .ADDR_WIDTH     (AW),
        .APP_DATA_WIDTH (DW),
        .LINE_WORDS     (LW),
        .ADDR_STEP      (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .line_req            (line_req),
        .line_addr           (line_addr),
        .line_ack            (line_ack),
        .busy                (busy),
        .done                (done),
        .rd_idx              (rd_idx),
        .rd_data             (rd_data),
        .init_calib_complete (init_calib_complete),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_ack = 0;
    int rmode = 0;
    int exp_lines = 0;
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Ready generator: 0 = always ready, 1 = random stalls, 2 = scripted stalls
    initial begin
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    app_rdy     = ($urandom_range(0, 9) < 7);
                    app_wdf_rdy = ($urandom_range(0, 9) < 7);
                end
                2: begin
                    app_rdy     = !((cyc - t_ack) inside {3, 4, 5});
                    app_wdf_rdy = !((cyc - t_ack) inside {7, 8});
                end
                default: begin
                    app_rdy     = 1'b1;
                    app_wdf_rdy = 1'b1;
                end
            endcase
        end
    end

    // Monitor: pops the reference on every accepted command / data beat
    initial begin
        bit            pend_c = 0;
        bit            pend_d = 0;
        logic [AW-1:0] hold_a = '0;
        logic [DW-1:0] hold_d = '0;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_c = 0;
                pend_d = 0;
            end else begin
                if (pend_c) check(app_en && app_addr == hold_a, "cmd_hold", DW'(app_addr), DW'(hold_a));
                if (pend_d) check(app_wdf_wren && app_wdf_data == hold_d, "data_hold", app_wdf_data, hold_d);
                check(app_wdf_end == app_wdf_wren && app_wdf_mask == '0, "end_mask",
                      DW'({app_wdf_end, app_wdf_mask}), DW'({app_wdf_wren, 16'h0}));
                pend_c = 0;
                pend_d = 0;
                if (app_en) begin
                    check(app_cmd == 3'b000, "app_cmd", DW'(app_cmd), '0);
                    if (app_rdy) begin
                        if (exp_addr_q.size() == 0) begin
                            check(1'b0, "cmd_unexpected", DW'(app_addr), '0);
                        end else begin
                            ea = exp_addr_q.pop_front();
                            check(app_addr == ea, "cmd_addr", DW'(app_addr), DW'(ea));
                        end
                    end else begin
                        pend_c = 1;
                        hold_a = app_addr;
                    end
                end
                if (app_wdf_wren) begin
                    if (app_wdf_rdy) begin
                        if (exp_data_q.size() == 0) begin
                            check(1'b0, "data_unexpected", app_wdf_data, '0);
                        end else begin
                            ed = exp_data_q.pop_front();
                            check(app_wdf_data == ed, "wdf_data", app_wdf_data, ed);
                        end
                    end else begin
                        pend_d = 1;
                        hold_d = app_wdf_data;
                    end
                end
                if (done) begin
                    check(exp_lines > 0, "done_unexpected", DW'(exp_lines), DW'(1));
                    if (exp_lines > 0) exp_lines--;
                    check(exp_addr_q.size() == 0 && exp_data_q.size() == 0, "beats_at_done",
                          DW'({exp_addr_q.size(), exp_data_q.size()}), '0);
                end
            end
        end
    end

    task automatic push_expected(input logic [AW-1:0] base);
        for (int k = 0; k < LW; k++) begin
            exp_addr_q.push_back(AW'((64'(base) + 64'(8 * k)) % (64'd1 << AW)));
            exp_data_q.push_back(bank[k]);
        end
        exp_lines++;
    endtask

    task automatic run_line(input logic [AW-1:0] base, input int m, input bit dir, input int cal_wait, output int lat);
        bit got;
        int c;
        for (int k = 0; k < LW; k++)
            bank[k] = dir ? {4{32'(k + 1)}} : {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        rmode     = m;
        line_addr = base;
        line_req  = 1'b1;
        if (cal_wait > 0) begin
            init_calib_complete = 1'b0;
            for (int n = 0; n < cal_wait; n++) begin
                @(negedge clk);
                check(!line_ack && !busy && !app_en, "calib_blocked", DW'({line_ack, busy, app_en}), '0);
            end
            @(posedge clk);
            #1;
            init_calib_complete = 1'b1;
        end
        got = 0;
        for (int n = 0; n < ((cal_wait > 0) ? 1 : 50) && !got; n++) begin
            @(negedge clk);
            if (line_ack) got = 1;
        end
        check(got, "ack_seen", DW'(got), DW'(1));
        lat = -1;
        if (!got) begin
            line_req = 1'b0;
            return;
        end
        check(!busy, "busy_at_ack", DW'(busy), '0);
        t_ack = cyc;
        push_expected(base);
        @(posedge clk);
        #1;
        line_req  = 1'b0;
        line_addr = AW'($urandom);
        if (m == 1) init_calib_complete = 1'b0;
        got = 0;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            c = cyc - t_ack;
            check(busy, "busy_in_line", DW'(busy), DW'(1));
            if (m == 2 && c == 4)
                check(!app_wdf_wren && app_en && app_addr == base + AW'(8), "stall_cmd",
                      DW'({app_wdf_wren, app_en, app_addr}), DW'({2'b01, base + AW'(8)}));
            if (m == 2 && c == 8)
                check(!app_en && app_wdf_wren, "stall_data", DW'({app_en, app_wdf_wren}), DW'(2'b01));
            if (done) begin
                got = 1;
                lat = c;
            end
        end
        check(got, "done_seen", DW'(got), DW'(1));
        init_calib_complete = 1'b1;
        @(negedge clk);
        check(!busy && !done, "idle_after_done", DW'({busy, done}), '0);
    endtask

    initial begin
        int lat;
        bit got;
        rst = 1'b1;
        line_req = 1'b1;
        line_addr = 27'h100;
        init_calib_complete = 1'b1;
        for (int k = 0; k < LW; k++) bank[k] = '0;
        repeat (3) @(negedge clk);
        check(!line_ack, "reset_ack", DW'(line_ack), '0);
        check(!busy && !done, "reset_busy_done", DW'({busy, done}), '0);
        check(!app_en && !app_wdf_wren && !app_wdf_end, "reset_en", DW'({app_en, app_wdf_wren, app_wdf_end}), '0);
        check(app_addr == '0 && rd_idx == '0, "reset_addr_idx", DW'({app_addr, rd_idx}), '0);
        check(app_wdf_data == '0, "reset_data", app_wdf_data, '0);
        @(posedge clk);
        #1;
        line_req = 1'b0;
        rst = 1'b0;

        run_line(27'h100, 0, 1, 0, lat);
        check(lat == 6, "latency_basic", DW'(lat), DW'(6));
        run_line(27'h100, 2, 1, 0, lat);
        check(lat == 11, "latency_stalls", DW'(lat), DW'(11));
        run_line(27'h7FF_FFF8, 0, 0, 0, lat);
        check(lat == 6, "latency_wrap", DW'(lat), DW'(6));
        run_line(27'h400, 0, 0, 10, lat);
        check(lat == 6, "latency_calib", DW'(lat), DW'(6));

        // Reset in the middle of beat 2; the line must be abandoned silently
        for (int k = 0; k < LW; k++) bank[k] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        rmode = 0;
        line_addr = 27'h200;
        line_req = 1'b1;
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (line_ack) got = 1;
        end
        check(got, "rst_test_ack", DW'(got), DW'(1));
        t_ack = cyc;
        push_expected(27'h200);
        @(posedge clk);
        #1;
        line_req = 1'b0;
        for (int n = 0; n < 20 && (cyc - t_ack) < 4; n++) @(negedge clk);
        check(app_en && app_addr == 27'h210, "beat2_before_rst", DW'({app_en, app_addr}), DW'({1'b1, 27'h210}));
        #1;
        rst = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_lines = 0;
        #1;
        check(!app_en && !app_wdf_wren && !busy && !done, "async_rst",
              DW'({app_en, app_wdf_wren, busy, done}), '0);
        check(rd_idx == '0 && app_addr == '0 && app_wdf_data == '0, "async_rst_regs",
              DW'({rd_idx, app_addr}) | app_wdf_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_line(27'h300, 0, 0, 0, lat);
        check(lat == 6, "latency_after_rst", DW'(lat), DW'(6));

        for (int i = 0; i < 10; i++) begin
            run_line(AW'($urandom), 1, 0, 0, lat);
            check(lat >= 6, "latency_random", DW'(lat), DW'(6));
        end

        repeat (3) @(negedge clk);
        check(exp_lines == 0 && exp_addr_q.size() == 0 && exp_data_q.size() == 0, "final_drain",
              DW'({exp_lines, exp_addr_q.size(), exp_data_q.size()}), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
